// File: rtl/wb_pkg.sv
// Writeback stage shared types: writeback source select,
// RISC-V load funct3 codes and the stage FSM encoding.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_AUX = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_MEM = 2'b01,
    S_RETIRE   = 2'b10
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks byte/half/word from the raw
// aligned memory word and sign/zero extends to DWIDTH.
// Ports: i_raw word, i_off byte offset, i_funct3 load type,
//        o_data extracted result.
module load_align
  import wb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]            i_raw,
  input  logic [$clog2(DWIDTH/8)-1:0]  i_off,
  input  logic [2:0]                   i_funct3,
  output logic [DWIDTH-1:0]            o_data
);

  localparam int OW = $clog2(DWIDTH/8);

  logic [OW-1:0] w_off_h;
  logic [OW-1:0] w_off_w;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_w;

  // halfword/word lanes ignore the low offset bits
  assign w_off_h = i_off & ~OW'(1);
  assign w_off_w = i_off & ~OW'(3);

  assign w_b = 8'(i_raw >> {i_off, 3'b000});
  assign w_h = 16'(i_raw >> {w_off_h, 3'b000});
  assign w_w = 32'(i_raw >> {w_off_w, 3'b000});

  // LD and reserved codes fall through to the full word
  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_LB:   o_data = DWIDTH'($signed(w_b));
      F3_LBU:  o_data = DWIDTH'(w_b);
      F3_LH:   o_data = DWIDTH'($signed(w_h));
      F3_LHU:  o_data = DWIDTH'(w_h);
      F3_LW:   o_data = DWIDTH'($signed(w_w));
      F3_LWU:  o_data = DWIDTH'(w_w);
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: accepts one instruction, waits for load data
// if needed, then retires it for one cycle with RF write,
// next-PC and retire count. Ports: handshake in, instruction
// fields, load response, RF port, next PC, retire outputs.
module writeback_pipe
  import wb_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AWIDTH-1:0]    pc_i,
  input  logic [DWIDTH-1:0]    alu_res_i,
  input  logic [DWIDTH-1:0]    aux_data_i,
  input  logic [1:0]           wbsel_i,
  input  logic                 brtaken_i,
  input  logic                 jump_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 rd_we_i,
  input  logic [2:0]           ld_funct3_i,
  input  logic                 mem_rsp_valid_i,
  input  logic [DWIDTH-1:0]    mem_rsp_data_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_addr_o,
  output logic [DWIDTH-1:0]    rf_data_o,
  output logic [AWIDTH-1:0]    next_pc_o,
  output logic                 pc_redirect_o,
  output logic                 retire_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);

  localparam int OW = $clog2(DWIDTH/8);

  state_e r_state;
  state_e w_state_nxt;

  logic [AWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_alu;
  logic [DWIDTH-1:0] r_aux;
  logic [1:0]        r_wbsel;
  logic              r_redir;
  logic [4:0]        r_rd;
  logic              r_we;
  logic [2:0]        r_f3;

  logic              w_accept;
  logic              w_go;
  logic              w_idle;
  logic [AWIDTH-1:0] w_pc;
  logic [AWIDTH-1:0] w_pc4;
  logic [DWIDTH-1:0] w_alu;
  logic [DWIDTH-1:0] w_aux;
  wbsel_e            w_sel;
  logic              w_redir;
  logic [4:0]        w_rd;
  logic              w_we;
  logic [DWIDTH-1:0] w_ld;
  logic [DWIDTH-1:0] w_data;

  assign w_idle     = (r_state == S_IDLE);
  assign in_ready_o = reset && w_idle;
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = (wbsel_i == WB_MEM) ?
                        S_WAIT_MEM : S_RETIRE;
      end
      S_WAIT_MEM: begin
        if (mem_rsp_valid_i) w_state_nxt = S_RETIRE;
      end
      S_RETIRE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    w_go = (w_state_nxt == S_RETIRE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= '0;
      r_alu   <= '0;
      r_aux   <= '0;
      r_wbsel <= '0;
      r_redir <= 1'b0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
    end else if (w_accept) begin
      r_pc    <= pc_i;
      r_alu   <= alu_res_i;
      r_aux   <= aux_data_i;
      r_wbsel <= wbsel_i;
      r_redir <= brtaken_i || jump_i;
      r_rd    <= rd_addr_i;
      r_we    <= rd_we_i;
      r_f3    <= ld_funct3_i;
    end
  end

  // Non-loads retire straight from the accept cycle, so the
  // result is built from live inputs there, else from captures.
  assign w_pc    = w_idle ? pc_i : r_pc;
  assign w_alu   = w_idle ? alu_res_i : r_alu;
  assign w_aux   = w_idle ? aux_data_i : r_aux;
  assign w_sel   = wbsel_e'(w_idle ? wbsel_i : r_wbsel);
  assign w_redir = w_idle ? (brtaken_i || jump_i) : r_redir;
  assign w_rd    = w_idle ? rd_addr_i : r_rd;
  assign w_we    = w_idle ? rd_we_i : r_we;
  assign w_pc4   = w_pc + AWIDTH'(4);

  load_align #(
    .DWIDTH (DWIDTH)
  ) u_align (
    .i_raw    (mem_rsp_data_i),
    .i_off    (r_alu[OW-1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_ld)
  );

  always_comb begin
    w_data = w_alu;
    unique case (w_sel)
      WB_ALU: w_data = w_alu;
      WB_MEM: w_data = w_ld;
      WB_PC4: w_data = DWIDTH'(w_pc4);
      WB_AUX: w_data = w_aux;
      default: w_data = w_alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_o        <= 1'b0;
      rf_addr_o      <= '0;
      rf_data_o      <= '0;
      next_pc_o      <= '0;
      pc_redirect_o  <= 1'b0;
      retire_o       <= 1'b0;
      retire_count_o <= '0;
    end else begin
      rf_we_o       <= 1'b0;
      pc_redirect_o <= 1'b0;
      retire_o      <= 1'b0;
      if (w_go) begin
        rf_we_o        <= w_we && (w_rd != 5'd0);
        rf_addr_o      <= w_rd;
        rf_data_o      <= w_data;
        next_pc_o      <= w_redir ? AWIDTH'(w_alu) : w_pc4;
        pc_redirect_o  <= w_redir;
        retire_o       <= 1'b1;
        retire_count_o <= retire_count_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_pipe.sv
// Self-checking bench for writeback_pipe: directed cases plus
// randomized instructions against a behavioural model.
module tb_writeback_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] alu_res_i;
  logic [31:0] aux_data_i;
  logic [1:0]  wbsel_i;
  logic        brtaken_i;
  logic        jump_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic [2:0]  ld_funct3_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [31:0] next_pc_o;
  logic        pc_redirect_o;
  logic        retire_o;
  logic [3:0]  retire_count_o;

  int          n_vec;
  int          n_err;
  logic [3:0]  m_cnt;
  logic [31:0] m_npc;

  writeback_pipe #(
    .DWIDTH    (32),
    .AWIDTH    (32),
    .CNT_WIDTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .pc_i            (pc_i),
    .alu_res_i       (alu_res_i),
    .aux_data_i      (aux_data_i),
    .wbsel_i         (wbsel_i),
    .brtaken_i       (brtaken_i),
    .jump_i          (jump_i),
    .rd_addr_i       (rd_addr_i),
    .rd_we_i         (rd_we_i),
    .ld_funct3_i     (ld_funct3_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .rf_we_o         (rf_we_o),
    .rf_addr_o       (rf_addr_o),
    .rf_data_o       (rf_data_o),
    .next_pc_o       (next_pc_o),
    .pc_redirect_o   (pc_redirect_o),
    .retire_o        (retire_o),
    .retire_count_o  (retire_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction using plain shift/mask arithmetic
  function automatic logic [31:0] mdl_load(input logic [31:0] raw,
                                           input int off,
                                           input logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'b000: begin
        v = (raw >> (off * 8)) & 32'hFF;
        if (v >= 32'd128) v = v - 32'd256;
      end
      3'b100: v = (raw >> (off * 8)) & 32'hFF;
      3'b001: begin
        v = (raw >> ((off / 2) * 16)) & 32'hFFFF;
        if (v >= 32'd32768) v = v - 32'd65536;
      end
      3'b101: v = (raw >> ((off / 2) * 16)) & 32'hFFFF;
      default: v = raw;
    endcase
    return v;
  endfunction

  task automatic run_instr(input logic [31:0] pc,
                           input logic [31:0] alu,
                           input logic [31:0] aux,
                           input logic [1:0]  sel,
                           input logic        br,
                           input logic        jmp,
                           input logic [4:0]  rd,
                           input logic        we,
                           input logic [2:0]  f3,
                           input logic [31:0] raw,
                           input int          dly,
                           input logic        junk);
    logic [31:0] e_data;
    logic [31:0] e_npc;
    logic        e_redir;
    chk("ready_idle", 64'(in_ready_o), 64'd1);
    in_valid_i      = 1'b1;
    pc_i            = pc;
    alu_res_i       = alu;
    aux_data_i      = aux;
    wbsel_i         = sel;
    brtaken_i       = br;
    jump_i          = jmp;
    rd_addr_i       = rd;
    rd_we_i         = we;
    ld_funct3_i     = f3;
    mem_rsp_valid_i = junk;
    mem_rsp_data_i  = ~raw;
    tick;
    in_valid_i      = 1'b0;
    mem_rsp_valid_i = 1'b0;
    pc_i            = $urandom;
    alu_res_i       = $urandom;
    aux_data_i      = $urandom;
    if (sel == 2'b01) begin
      for (int i = 0; i < dly; i++) begin
        chk("wait_ready", 64'(in_ready_o), 64'd0);
        chk("wait_noretire", 64'(retire_o), 64'd0);
        tick;
      end
      chk("wait_rfwe", 64'(rf_we_o), 64'd0);
      chk("wait_noretire", 64'(retire_o), 64'd0);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = raw;
      tick;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = $urandom;
    end
    case (sel)
      2'b00:   e_data = alu;
      2'b01:   e_data = mdl_load(raw, int'(alu % 4), f3);
      2'b10:   e_data = pc + 32'd4;
      default: e_data = aux;
    endcase
    e_redir = br || jmp;
    e_npc   = e_redir ? alu : pc + 32'd4;
    m_cnt   = m_cnt + 4'd1;
    m_npc   = e_npc;
    in_valid_i = 1'b1;
    wbsel_i    = 2'b00;
    chk("ret_pulse", 64'(retire_o), 64'd1);
    chk("ret_rfwe", 64'(rf_we_o), 64'(we && rd != 5'd0));
    chk("ret_addr", 64'(rf_addr_o), 64'(rd));
    chk("ret_data", 64'(rf_data_o), 64'(e_data));
    chk("ret_npc", 64'(next_pc_o), 64'(e_npc));
    chk("ret_redir", 64'(pc_redirect_o), 64'(e_redir));
    chk("ret_count", 64'(retire_count_o), 64'(m_cnt));
    chk("ret_ready", 64'(in_ready_o), 64'd0);
    tick;
    in_valid_i = 1'b0;
    chk("post_retire", 64'(retire_o), 64'd0);
    chk("post_rfwe", 64'(rf_we_o), 64'd0);
    chk("post_redir", 64'(pc_redirect_o), 64'd0);
    chk("post_npc_hold", 64'(next_pc_o), 64'(m_npc));
    chk("post_count", 64'(retire_count_o), 64'(m_cnt));
    chk("post_ready", 64'(in_ready_o), 64'd1);
  endtask

  task automatic chk_reset_outs;
    chk("rst_rfwe", 64'(rf_we_o), 64'd0);
    chk("rst_addr", 64'(rf_addr_o), 64'd0);
    chk("rst_data", 64'(rf_data_o), 64'd0);
    chk("rst_npc", 64'(next_pc_o), 64'd0);
    chk("rst_redir", 64'(pc_redirect_o), 64'd0);
    chk("rst_retire", 64'(retire_o), 64'd0);
    chk("rst_count", 64'(retire_count_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    m_cnt           = '0;
    m_npc           = '0;
    reset           = 1'b0;
    in_valid_i      = 1'b0;
    pc_i            = '0;
    alu_res_i       = '0;
    aux_data_i      = '0;
    wbsel_i         = '0;
    brtaken_i       = 1'b0;
    jump_i          = 1'b0;
    rd_addr_i       = '0;
    rd_we_i         = 1'b0;
    ld_funct3_i     = '0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;

    tick;
    tick;
    chk_reset_outs;
    reset = 1'b1;
    #1;
    chk("release_ready", 64'(in_ready_o), 64'd1);

    // ALU op
    run_instr(32'h1000, 32'h1234, 32'h0, 2'b00, 1'b0, 1'b0,
              5'd5, 1'b1, 3'b000, 32'h0, 0, 1'b0);
    // LB / LBU at offset 3
    run_instr(32'h2000, 32'h103, 32'h0, 2'b01, 1'b0, 1'b0,
              5'd7, 1'b1, 3'b000, 32'h80FF_0000, 0, 1'b0);
    chk("lb_value", 64'(rf_data_o), 64'h0000_0000_FFFF_FF80);
    run_instr(32'h2004, 32'h103, 32'h0, 2'b01, 1'b0, 1'b0,
              5'd8, 1'b1, 3'b100, 32'h80FF_0000, 0, 1'b1);
    chk("lbu_value", 64'(rf_data_o), 64'h0000_0000_0000_0080);

    // spurious response while idle
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hDEAD_BEEF;
    tick;
    mem_rsp_valid_i = 1'b0;
    chk("spur_retire", 64'(retire_o), 64'd0);
    chk("spur_count", 64'(retire_count_o), 64'(m_cnt));
    chk("spur_ready", 64'(in_ready_o), 64'd1);

    // late response, 4 cycles
    run_instr(32'h3000, 32'h2002, 32'h0, 2'b01, 1'b0, 1'b0,
              5'd9, 1'b1, 3'b001, 32'h8001_7FFF, 4, 1'b1);

    // jump with rd=0
    run_instr(32'h100, 32'h200, 32'h0, 2'b10, 1'b0, 1'b1,
              5'd0, 1'b1, 3'b000, 32'h0, 0, 1'b0);
    chk("jal_data", 64'(rf_data_o), 64'h104);

    // reset during WAIT_MEM discards the load
    in_valid_i  = 1'b1;
    wbsel_i     = 2'b01;
    rd_addr_i   = 5'd3;
    rd_we_i     = 1'b1;
    alu_res_i   = 32'h40;
    ld_funct3_i = 3'b010;
    tick;
    in_valid_i = 1'b0;
    tick;
    chk("mid_wait_ready", 64'(in_ready_o), 64'd0);
    reset           = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h1234_5678;
    tick;
    mem_rsp_valid_i = 1'b0;
    chk_reset_outs;
    reset = 1'b1;
    m_cnt = '0;
    m_npc = '0;
    tick;
    chk("after_rst_retire", 64'(retire_o), 64'd0);
    chk("after_rst_ready", 64'(in_ready_o), 64'd1);

    // counter wrap: 15 retires bring it to max, next wraps
    for (int k = 0; k < 15; k++)
      run_instr($urandom, $urandom, $urandom, 2'b11, 1'b0,
                1'b0, 5'($urandom), 1'b1, 3'b000, 32'h0, 0,
                1'b0);
    chk("cnt_max", 64'(retire_count_o), 64'hF);
    run_instr(32'h500, 32'h11, 32'h22, 2'b00, 1'b1, 1'b0,
              5'd1, 1'b1, 3'b000, 32'h0, 0, 1'b0);
    chk("cnt_wrap", 64'(retire_count_o), 64'd0);

    // randomized instructions
    for (int k = 0; k < 60; k++)
      run_instr($urandom, $urandom, $urandom,
                2'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom),
                5'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)), $urandom,
                int'($urandom_range(0, 3)), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
